// File: rtl/dma_bus_controller.sv
// dma_bus_controller
//   Block-copy DMA engine for the single-cycle MIPS data bus. Copies dma_len
//   words from dma_src to dma_dst, one READ/WRITE pair per word, stalling the
//   CPU through hal while it owns the data-memory port. All outputs are
//   decoded from registered state only, so nothing combinationally depends on
//   an input.
//
//   Optional feature macro: DMA_BURST_LIMIT_EN
//     When defined, at most BURST_MAX words are moved per bus tenure.
//     Afterwards the controller re-arbitrates through ARB, which gives the CPU
//     at least one unhalted cycle.
//     When undefined, the whole transfer runs in one tenure.
//
//   Ports
//     clk, rst        : clock, synchronous active-high reset
//     dma_start       : one-cycle request pulse (honoured only in IDLE)
//     dma_src/dst/len : transfer parameters, latched on start
//     cpu_mem_access  : CPU load/store this cycle (arbitration input)
//     mem_rdata       : data memory / io read data
//     hal             : CPU halt while DMA owns the bus
//     bus_grant_dma   : data-bus mux select, 1 = DMA source
//     dma_addr        : bus address while granted
//     dma_wdata       : bus write data while granted
//     dma_memread     : read strobe
//     dma_memwrite    : write strobe
//     dma_busy        : transfer in progress
//     dma_done        : one-cycle completion pulse
module dma_bus_controller #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              cpu_mem_access,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              hal,
  output logic              bus_grant_dma,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_wdata,
  output logic              dma_memread,
  output logic              dma_memwrite,
  output logic              dma_busy,
  output logic              dma_done
);

  if (BURST_MAX == 0) begin : g_burst_max_check
    $error("BURST_MAX must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] buffer;
  logic              burst_hit;

`ifdef DMA_BURST_LIMIT_EN
  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

  // Number of WRITE states completed in the current tenure.
  logic [BURST_W-1:0] burst_cnt;

  assign burst_hit = (burst_cnt == BURST_W'(BURST_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (state_nxt == ARB) begin
      burst_cnt <= '0;
    end else if (state == WRITE) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dma_start) state_nxt = (dma_len != '0) ? ARB : DONE;
      ARB:   if (!cpu_mem_access) state_nxt = READ;
      READ:  state_nxt = WRITE;
      WRITE: begin
        if (count == LEN_W'(1))  state_nxt = DONE;
        else if (burst_hit)      state_nxt = ARB;
        else                     state_nxt = READ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      count  <= '0;
      buffer <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (dma_start && (dma_len != '0)) begin
            src   <= dma_src;
            dst   <= dma_dst;
            count <= dma_len;
          end
        end
        READ:  buffer <= mem_rdata;
        WRITE: begin
          // Address arithmetic wraps modulo 2^ADDR_W by construction.
          src   <= src + ADDR_W'(ADDR_STEP);
          dst   <= dst + ADDR_W'(ADDR_STEP);
          count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hal           = 1'b0;
    bus_grant_dma = 1'b0;
    dma_addr      = '0;
    dma_wdata     = '0;
    dma_memread   = 1'b0;
    dma_memwrite  = 1'b0;
    dma_busy      = 1'b0;
    dma_done      = 1'b0;
    case (state)
      ARB: dma_busy = 1'b1;
      READ: begin
        dma_busy      = 1'b1;
        hal           = 1'b1;
        bus_grant_dma = 1'b1;
        dma_memread   = 1'b1;
        dma_addr      = src;
      end
      WRITE: begin
        dma_busy      = 1'b1;
        hal           = 1'b1;
        bus_grant_dma = 1'b1;
        dma_memwrite  = 1'b1;
        dma_addr      = dst;
        dma_wdata     = buffer;
      end
      DONE: begin
        dma_busy = 1'b1;
        dma_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_controller.sv
module tb_dma_bus_controller;

  localparam int BM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dma_start = 1'b0;
  logic [31:0] dma_src = '0;
  logic [31:0] dma_dst = '0;
  logic [15:0] dma_len = '0;
  logic        cpu_mem_access = 1'b0;
  logic [31:0] mem_rdata;
  logic        hal;
  logic        bus_grant_dma;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_memread;
  logic        dma_memwrite;
  logic        dma_busy;
  logic        dma_done;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t  exp_q[$];
  op_t  mon_e;
  logic hal_trace[$];

  dma_bus_controller #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .ADDR_STEP(4), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_src(dma_src),
    .dma_dst(dma_dst), .dma_len(dma_len), .cpu_mem_access(cpu_mem_access),
    .mem_rdata(mem_rdata), .hal(hal), .bus_grant_dma(bus_grant_dma),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_memread(dma_memread),
    .dma_memwrite(dma_memwrite), .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // Source memory image: fixed word at 0x10, hashed pattern elsewhere.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign mem_rdata = mem_model(dma_addr);

  // Bus-operation scoreboard: every strobe must match the next expected op.
  always @(negedge clk) begin
    if (dma_memread || dma_memwrite) begin
      checks++;
      if (dma_memwrite) wr_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_op unexpected: rd=%0b wr=%0b addr=%h, required no bus op",
                 dma_memread, dma_memwrite, dma_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if ((dma_memread && dma_memwrite) || bus_grant_dma !== 1'b1 || hal !== 1'b1 ||
            dma_memwrite !== mon_e.wr || dma_memread !== !mon_e.wr ||
            dma_addr !== mon_e.addr || (mon_e.wr && dma_wdata !== mon_e.data)) begin
          errors++;
          $display("FAIL bus_op: got rd=%0b wr=%0b grant=%0b hal=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                   dma_memread, dma_memwrite, bus_grant_dma, hal, dma_addr, dma_wdata,
                   mon_e.wr, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: src + 32'(4 * i), data: 32'h0});
      exp_q.push_back('{wr: 1'b1, addr: dst + 32'(4 * i), data: mem_model(src + 32'(4 * i))});
    end
  endtask

  // Leaves the bench 1 ns into cycle 1 (the first cycle after the start edge).
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int cma_cycles);
    @(posedge clk); #1;
    dma_src = src; dma_dst = dst; dma_len = 16'(len);
    dma_start = 1'b1;
    cpu_mem_access = (cma_cycles > 0);
    push_copy(src, dst, len);
    @(posedge clk); #1;
    dma_start = 1'b0;
    cpu_mem_access = (1 < cma_cycles);
  endtask

  task automatic observe(input int budget, input int cma_cycles, input int restart_cyc,
                         output int done_cyc, output int hal_cnt, output int arb_cnt,
                         output int done_cnt);
    done_cyc = 0; hal_cnt = 0; arb_cnt = 0; done_cnt = 0;
    hal_trace.delete();
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      hal_trace.push_back(hal);
      if (hal) hal_cnt++;
      if (dma_busy && !hal && !dma_done) arb_cnt++;
      if (dma_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 2) break;
      @(posedge clk); #1;
      cpu_mem_access = (cyc + 1 < cma_cycles);
      dma_start = (cyc + 1 == restart_cyc);
    end
    cpu_mem_access = 1'b0;
    dma_start = 1'b0;
  endtask

  function automatic int expected_done(input int len);
`ifdef DMA_BURST_LIMIT_EN
    return 2 + 2 * len + ((len + BM - 1) / BM - 1);
`else
    return 2 + 2 * len;
`endif
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hal, bus_grant_dma, dma_addr, dma_wdata, dma_memread, dma_memwrite, dma_busy, dma_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hal=%0b grant=%0b addr=%h wdata=%h rd=%0b wr=%0b busy=%0b done=%0b, required all 0",
               hal, bus_grant_dma, dma_addr, dma_wdata, dma_memread, dma_memwrite, dma_busy, dma_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_word;
    int dc, hc, ac, dn;
    start_xfer(32'h10, 32'h40, 1, 0);
    observe(20, 0, 0, dc, hc, ac, dn);
    checks++;
    if (ac != 1 || hc != 2 || dc != 4 || dn != 1) begin
      errors++;
      $display("FAIL single_word: arb=%0d hal=%0d done_cyc=%0d done_cnt=%0d, required 1 2 4 1", ac, hc, dc, dn);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_word_ops: %0d ops outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_contention;
    int dc, hc, ac, dn;
    start_xfer(32'h80, 32'hC0, 2, 3);
    observe(30, 3, 0, dc, hc, ac, dn);
    checks++;
    if (ac != 3 || hc != 4 || dc != 8 || dn != 1) begin
      errors++;
      $display("FAIL contention: arb=%0d hal=%0d done_cyc=%0d done_cnt=%0d, required 3 4 8 1", ac, hc, dc, dn);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL contention_ops: %0d ops outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero_length;
    int dc, hc, ac, dn;
    start_xfer(32'h100, 32'h200, 0, 0);
    observe(10, 0, 0, dc, hc, ac, dn);
    checks++;
    if (dc != 1 || hc != 0 || dn != 1) begin
      errors++;
      $display("FAIL zero_length: done_cyc=%0d hal=%0d done_cnt=%0d, required 1 0 1", dc, hc, dn);
    end
  endtask

  task automatic test_restart_ignored;
    int dc, hc, ac, dn, w0;
    w0 = wr_count;
    start_xfer(32'h400, 32'h500, 4, 0);
    // Different parameters presented with the stray start pulse.
    dma_src = 32'h900; dma_dst = 32'hA00; dma_len = 16'd2;
    observe(40, 0, 3, dc, hc, ac, dn);
    checks++;
    if (wr_count - w0 != 4 || dc != expected_done(4) || dn != 1) begin
      errors++;
      $display("FAIL restart_ignored: writes=%0d done_cyc=%0d done_cnt=%0d, required 4 %0d 1",
               wr_count - w0, dc, dn, expected_done(4));
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_ops: %0d ops outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int dn;
    start_xfer(32'h200, 32'h300, 4, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dma_memwrite !== 1'b1 || dma_addr !== 32'h304) begin
      errors++;
      $display("FAIL reset_mid_phase: wr=%0b addr=%h, required 1 00000304", dma_memwrite, dma_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({hal, bus_grant_dma, dma_addr, dma_wdata, dma_memread, dma_memwrite, dma_busy, dma_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: hal=%0b grant=%0b addr=%h wdata=%h rd=%0b wr=%0b busy=%0b done=%0b, required all 0",
               hal, bus_grant_dma, dma_addr, dma_wdata, dma_memread, dma_memwrite, dma_busy, dma_done);
    end
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (dma_done) dn++;
    end
    checks++;
    if (dn != 0 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_abort: done_cnt=%0d outstanding=%0d, required 0 4", dn, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_addr_wrap;
    int dc, hc, ac, dn;
    start_xfer(32'hFFFF_FFFC, 32'h600, 2, 0);
    observe(30, 0, 0, dc, hc, ac, dn);
    checks++;
    if (dc != expected_done(2) || hc != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL addr_wrap: done_cyc=%0d hal=%0d outstanding=%0d, required %0d 4 0",
               dc, hc, exp_q.size(), expected_done(2));
    end
    exp_q.delete();
  endtask

  task automatic test_burst;
    int dc, hc, ac, dn, run;
    int runs[$];
    int exp_runs[$];
`ifdef DMA_BURST_LIMIT_EN
    exp_runs = '{4, 4, 2};
`else
    exp_runs = '{10};
`endif
    start_xfer(32'h1000, 32'h2000, 5, 0);
    observe(40, 0, 0, dc, hc, ac, dn);
    run = 0;
    foreach (hal_trace[i]) begin
      if (hal_trace[i]) run++;
      else if (run != 0) begin runs.push_back(run); run = 0; end
    end
    if (run != 0) runs.push_back(run);
    checks++;
    if (runs != exp_runs) begin
      errors++;
      $display("FAIL burst_hal_runs: got %0d runs first=%0d, required %0d runs first=%0d",
               runs.size(), (runs.size() > 0) ? runs[0] : -1, exp_runs.size(), exp_runs[0]);
    end
    checks++;
    if (dc != expected_done(5) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_done: done_cyc=%0d outstanding=%0d, required %0d 0", dc, exp_q.size(), expected_done(5));
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int dc, hc, ac, dn, len;
    logic [31:0] s, d;
    for (int k = 0; k < 3; k++) begin
      len = int'($urandom_range(1, 6));
      s = $urandom() & 32'hFFFF_FFFC;
      d = $urandom() & 32'hFFFF_FFFC;
      start_xfer(s, d, len, 0);
      observe(40, 0, 0, dc, hc, ac, dn);
      checks++;
      if (dc != expected_done(len) || hc != 2 * len || dn != 1 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL back_to_back[%0d]: len=%0d done_cyc=%0d hal=%0d done_cnt=%0d outstanding=%0d, required %0d %0d 1 0",
                 k, len, dc, hc, dn, exp_q.size(), expected_done(len), 2 * len);
      end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_contention();
    test_zero_length();
    test_restart_ignored();
    test_reset_mid();
    test_addr_wrap();
    test_burst();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
